audio_tx_feeder: RTL and testbench

//  Elastic sample buffer directly upstream of the SPI audio transmitter. Accepts 16-bit samples

---
 rtl/audio_pkg.sv | 12 +
 rtl/sample_fifo.sv | 60 ++++++
 rtl/audio_tx_feeder.sv | 103 ++++++++++
 tb/tb_audio_tx_feeder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the audio transmit feeder.
//   SAMPLE_W      - width of one audio sample
//   BITS_PER_WORD - SPI clock falls the transmitter spends on one word
//   BUSY_W        - width of the word counter (holds 0..BITS_PER_WORD)
//   sample_t      - one audio sample
package audio_pkg;
    localparam int SAMPLE_W      = 16;
    localparam int BITS_PER_WORD = 16;
    localparam int BUSY_W        = $clog2(BITS_PER_WORD) + 1;

    typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: DEPTH-entry flop-array FIFO of audio samples with a
// combinational head read. Writes become visible at the head on the next
// cycle (no bypass). The caller must not write when full or read when empty.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   wr_en, wr_data      - write a sample at the tail
//   rd_en               - drop the head entry
//   head                - current head entry (undefined when empty)
//   level               - occupancy 0..DEPTH
//   full, empty         - occupancy flags
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  sample_t                    wr_data,
    input  logic                       rd_en,
    output sample_t                    head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    sample_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two; level
    // carries the extra bit that separates full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sample storage carries no reset; validity is tracked by level.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);
endmodule

// File: rtl/audio_tx_feeder.sv
// audio_tx_feeder: elastic sample buffer in front of the SPI audio
// transmitter. The transmitter has no ready, so this block mirrors its word
// counter from sclk/sel and pops exactly when the transmitter loads a word.
// Optional feature macro: AUDIO_UNDERRUN_FILL_EN - when defined, an empty
// buffer repeats the last sample instead of stalling the stream.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   sclk, sel               - SPI clock and active-low select (clk-synchronous)
//   sample_in/valid/ready   - sample input handshake (ready = !full)
//   data_out, valid_out     - word offered to the transmitter
//   level                   - FIFO occupancy
//   underrun_cnt            - saturating underrun event count
//   overflow                - sticky: a sample was dropped while full
module audio_tx_feeder
    import audio_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sclk,
    input  logic                     sel,
    input  sample_t                  sample_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output sample_t                  data_out,
    output logic                     valid_out,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         underrun_cnt,
    output logic                     overflow
);
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BITS_PER_WORD);

    logic [BUSY_W-1:0] busy;
    logic              sclk_prev;
    sample_t           last_sample;
    sample_t           head;
    logic              full;
    logic              empty;
    logic              fall;
    logic              idle;
    logic              load;
    logic              pop;
    logic              push;
    logic              underrun;

    sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (sample_in),
        .rd_en   (pop),
        .head    (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    assign fall         = sclk_prev & ~sclk;
    assign idle         = (busy == '0);
    assign sample_ready = ~full;
    // Full refuses the push even when a pop happens in the same cycle.
    assign push         = sample_valid & ~full;

`ifdef AUDIO_UNDERRUN_FILL_EN
    // An idle, selected transmitter always gets a word: the last sample
    // stands in when the buffer is empty, and each fill word is one underrun.
    assign valid_out = idle & (~empty | ~sel);
    assign data_out  = empty ? last_sample : head;
    assign load      = ~sel & valid_out;
    assign underrun  = load & empty;
`else
    assign valid_out = idle & ~empty;
    assign data_out  = empty ? sample_t'(0) : head;
    assign load      = ~sel & valid_out;
    assign underrun  = fall & ~sel & idle & empty;
`endif

    assign pop = load & ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy         <= '0;
            sclk_prev    <= 1'b0;
            last_sample  <= '0;
            underrun_cnt <= '0;
            overflow     <= 1'b0;
        end else begin
            sclk_prev <= sclk;
            // A load outranks a falling edge; while deselected the count
            // freezes so a resumed select continues the same word.
            if (load) begin
                busy <= BUSY_W'(1);
            end else if (~sel & fall & ~idle) begin
                busy <= (busy == BUSY_LAST) ? '0 : busy + 1'b1;
            end
            if (pop) last_sample <= head;
            if (underrun && underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
            if (sample_valid & full) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_audio_tx_feeder.sv
module tb_audio_tx_feeder;
    localparam int DEPTH = 16;
    localparam int CNT_W = 8;
    localparam int UMAX  = (1 << CNT_W) - 1;
`ifdef AUDIO_UNDERRUN_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              sclk = 1'b0;
    logic              sel = 1'b1;
    logic [15:0]       sample_in = '0;
    logic              sample_valid = 1'b0;
    logic              sample_ready;
    logic [15:0]       data_out;
    logic              valid_out;
    logic [4:0]        level;
    logic [CNT_W-1:0]  underrun_cnt;
    logic              overflow;

    int tests = 0;
    int fails = 0;

    audio_tx_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .sclk         (sclk),
        .sel          (sel),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .level        (level),
        .underrun_cnt (underrun_cnt),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: buffer as a queue, transmitter as "falls left in word".
    int          mq[$];
    int          m_left;
    bit          m_sclk_prev;
    logic [15:0] m_last;
    int          m_ucnt;
    bit          m_ovf;

    function automatic bit exp_valid();
        return (m_left == 0) && (mq.size() != 0 || (FILL && !sel));
    endfunction

    function automatic logic [15:0] exp_data();
        if (mq.size() != 0) return 16'(mq[0]);
        return FILL ? m_last : 16'h0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_left = 0; m_sclk_prev = 0; m_last = '0; m_ucnt = 0; m_ovf = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit fall  = m_sclk_prev && !sclk;
        bit idle  = (m_left == 0);
        bit empty = (mq.size() == 0);
        bit full  = (mq.size() == DEPTH);
        if (!sel && exp_valid()) begin
            if (!empty) m_last = 16'(mq.pop_front());
            else if (m_ucnt < UMAX) m_ucnt++;
            m_left = 16;
        end else if (!sel && fall && !idle) begin
            m_left--;
        end else if (!FILL && !sel && fall && idle && empty) begin
            if (m_ucnt < UMAX) m_ucnt++;
        end
        if (sample_valid) begin
            if (!full) mq.push_back(int'(sample_in));
            else m_ovf = 1;
        end
        m_sclk_prev = sclk;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        sclk = 1'b1; cycle();
        sclk = 1'b0; cycle();
    endtask

    task automatic push(input logic [15:0] v);
        sample_valid = 1'b1; sample_in = v; cycle();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        sel = 1'b1; sclk = 1'b0; sample_valid = 1'b0; sample_in = '0;
        reset = 1'b1; cycle(); cycle();
        reset = 1'b0; cycle();
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (level !== 5'd0) begin fails++; $display("FAIL reset_level got %0d exp 0", level); end
        tests++; if (sample_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", sample_ready); end
        tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", valid_out); end
        tests++; if (data_out !== 16'h0) begin fails++; $display("FAIL reset_data got %h exp 0000", data_out); end
        tests++; if (underrun_cnt !== '0) begin fails++; $display("FAIL reset_ucnt got %0d exp 0", underrun_cnt); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    endtask

    task automatic test_two_words();
        bit bad = 0;
        do_reset();
        push(16'h1234); push(16'hABCD);
        tests++; if (level !== 5'd2) begin fails++; $display("FAIL tw_level2 got %0d exp 2", level); end
        tests++; if (data_out !== 16'h1234 || valid_out !== 1'b1) begin fails++; $display("FAIL tw_head1 got %h/%b exp 1234/1", data_out, valid_out); end
        sel = 1'b0; cycle();
        tests++; if (level !== 5'd1 || valid_out !== 1'b0) begin fails++; $display("FAIL tw_pop1 got level %0d valid %b exp 1/0", level, valid_out); end
        tests++; if (data_out !== 16'hABCD) begin fails++; $display("FAIL tw_next_head got %h exp abcd", data_out); end
        for (int i = 0; i < 15; i++) begin pulse(); if (valid_out !== 1'b0) bad = 1; end
        tests++; if (bad) begin fails++; $display("FAIL tw_busy_low got 1 exp 0 during falls 1..15"); end
        pulse();
        tests++; if (valid_out !== 1'b1 || data_out !== 16'hABCD) begin fails++; $display("FAIL tw_word2 got %h/%b exp abcd/1", data_out, valid_out); end
        cycle();
        tests++; if (level !== 5'd0 || valid_out !== 1'b0) begin fails++; $display("FAIL tw_pop2 got level %0d valid %b exp 0/0", level, valid_out); end
        for (int i = 0; i < 16; i++) pulse();
        tests++; if (valid_out !== FILL || data_out !== (FILL ? 16'hABCD : 16'h0)) begin fails++; $display("FAIL tw_drained got %h/%b exp %h/%b", data_out, valid_out, FILL ? 16'hABCD : 16'h0, FILL); end
    endtask

    task automatic test_overflow();
        logic [15:0] vals [DEPTH];
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin vals[i] = 16'($urandom); push(vals[i]); end
        tests++; if (level !== 5'd16 || sample_ready !== 1'b0) begin fails++; $display("FAIL ov_full got level %0d ready %b exp 16/0", level, sample_ready); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ov_early got %b exp 0", overflow); end
        push(16'hDEAD);
        tests++; if (overflow !== 1'b1 || level !== 5'd16) begin fails++; $display("FAIL ov_drop got ovf %b level %0d exp 1/16", overflow, level); end
        sel = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tests++; if (valid_out !== 1'b1 || data_out !== vals[i]) begin fails++; $display("FAIL ov_drain%0d got %h/%b exp %h/1", i, data_out, valid_out, vals[i]); end
            cycle();
            for (int k = 0; k < 16; k++) pulse();
        end
        tests++; if (level !== 5'd0 || overflow !== 1'b1) begin fails++; $display("FAIL ov_end got level %0d ovf %b exp 0/1", level, overflow); end
    endtask

    task automatic test_underrun();
        do_reset();
        sel = 1'b0; cycle();
        for (int i = 0; i < 5; i++) pulse();
        tests++; if (underrun_cnt !== CNT_W'(FILL ? 1 : 5)) begin fails++; $display("FAIL ur_cnt5 got %0d exp %0d", underrun_cnt, FILL ? 1 : 5); end
        tests++; if (valid_out !== 1'b0 || data_out !== 16'h0) begin fails++; $display("FAIL ur_out got %h/%b exp 0000/0", data_out, valid_out); end
        for (int i = 0; i < 260; i++) pulse();
        tests++; if (underrun_cnt !== CNT_W'(FILL ? 17 : UMAX)) begin fails++; $display("FAIL ur_sat got %0d exp %0d", underrun_cnt, FILL ? 17 : UMAX); end
    endtask

    task automatic test_deselect();
        bit bad = 0;
        do_reset();
        tests++; if (underrun_cnt !== '0) begin fails++; $display("FAIL ds_ucnt_clr got %0d exp 0", underrun_cnt); end
        push(16'h1111); push(16'h2222);
        sel = 1'b0; cycle();
        for (int i = 0; i < 7; i++) pulse();
        sel = 1'b1;
        for (int i = 0; i < 3; i++) pulse();
        tests++; if (valid_out !== 1'b0 || level !== 5'd1) begin fails++; $display("FAIL ds_frozen got valid %b level %0d exp 0/1", valid_out, level); end
        sel = 1'b0;
        for (int i = 0; i < 8; i++) begin pulse(); if (valid_out !== 1'b0) bad = 1; end
        tests++; if (bad) begin fails++; $display("FAIL ds_resume got 1 exp 0 before fall 16"); end
        pulse();
        tests++; if (valid_out !== 1'b1 || data_out !== 16'h2222) begin fails++; $display("FAIL ds_done got %h/%b exp 2222/1", data_out, valid_out); end
        cycle();
        tests++; if (level !== 5'd0) begin fails++; $display("FAIL ds_pop got %0d exp 0", level); end
    endtask

    task automatic test_reset_midword();
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) push(16'(i + 16'h100));
        sel = 1'b0; cycle();
        for (int i = 0; i < 7; i++) pulse();
        sel = 1'b1;
        reset = 1'b1; cycle();
        tests++; if (level !== 5'd0 || valid_out !== 1'b0 || data_out !== 16'h0) begin fails++; $display("FAIL rm_out got level %0d %h/%b exp 0 0000/0", level, data_out, valid_out); end
        tests++; if (overflow !== 1'b0 || sample_ready !== 1'b1) begin fails++; $display("FAIL rm_flags got ovf %b ready %b exp 0/1", overflow, sample_ready); end
        reset = 1'b0; cycle();
        push(16'h7777);
        sel = 1'b0;
        #1;
        tests++; if (valid_out !== 1'b1 || data_out !== 16'h7777 || level !== 5'd1) begin fails++; $display("FAIL rm_fresh got %h/%b level %0d exp 7777/1 1", data_out, valid_out, level); end
        sel = 1'b1;
    endtask

    task automatic test_random();
        int pv;
        do_reset();
        model_reset();
        for (int ph = 0; ph < 3; ph++) begin
            pv = (ph == 0) ? 80 : ((ph == 1) ? 8 : 45);
            for (int n = 0; n < 1500; n++) begin
                sclk         = 1'($urandom_range(0, 1));
                sel          = ($urandom_range(0, 99) < 12);
                sample_valid = ($urandom_range(0, 99) < pv);
                sample_in    = 16'($urandom);
                model_step();
                cycle();
                tests++;
                if (valid_out !== exp_valid() || data_out !== exp_data() || level !== 5'(mq.size())
                    || sample_ready !== (mq.size() < DEPTH) || underrun_cnt !== CNT_W'(m_ucnt)
                    || overflow !== m_ovf) begin
                    fails++;
                    $display("FAIL rnd_cyc%0d got v%b d%h l%0d r%b u%0d o%b exp v%b d%h l%0d r%b u%0d o%b",
                             n, valid_out, data_out, level, sample_ready, underrun_cnt, overflow,
                             exp_valid(), exp_data(), mq.size(), mq.size() < DEPTH, m_ucnt, m_ovf);
                end
            end
        end
        sample_valid = 1'b0; sel = 1'b1;
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_overflow();
        test_underrun();
        test_deselect();
        test_reset_midword();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
